// File: rtl/video_sampling_arbiter.sv
// video_sampling_arbiter
// Shares one DDR write master between CH_NUM downsampling channels. A
// round-robin arbiter picks a channel whose ping-pong half is full, then one
// BURST_LEN-beat burst is read out of that half and written to the channel's
// frame buffer at its running write pointer. Frame-end pulses rewind a
// channel's pointer and half, but only between bursts.
module video_sampling_arbiter #(
  parameter int CH_NUM       = 4,
  parameter int RD_ADDR_LEN  = 5,
  parameter int DQ_WIDTH     = 32,
  parameter int BURST_LEN    = 16,
  parameter int ADDR_WIDTH   = 28,
  parameter int CH_STRIDE    = 4096,
  parameter int FRAME_BURSTS = 225
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CH_NUM-1:0]              ch_data_ready,
  input  logic [CH_NUM-1:0]              ch_frame_end,
  input  logic [CH_NUM*DQ_WIDTH*8-1:0]   ch_rd_data,
  output logic [CH_NUM-1:0]              ch_rd_valid,
  output logic [RD_ADDR_LEN-1:0]         ch_rd_addr,
  output logic                           ddr_wr_req,
  input  logic                           ddr_wr_ack,
  output logic [ADDR_WIDTH-1:0]          ddr_wr_addr,
  output logic [7:0]                     ddr_wr_len,
  input  logic                           ddr_wr_data_req,
  output logic [DQ_WIDTH*8-1:0]          ddr_wr_data,
  input  logic                           ddr_wr_done,
  output logic [3:0]                     grant_id
);

  localparam int BEAT_W = DQ_WIDTH * 8;
  localparam int SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  // Beat counter must reach BURST_LEN itself, so it is one bit wider than
  // the in-half address field.
  localparam int BCNT_W = RD_ADDR_LEN;
  localparam int FCNT_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  // FSM registers
  state_t                  r_state;
  logic [SEL_W-1:0]        r_grant;
  logic [SEL_W-1:0]        r_last_grant;
  logic [CH_NUM-1:0]       r_rd_valid;
  logic [RD_ADDR_LEN-1:0]  r_rd_addr;
  logic                    r_wr_req;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [BCNT_W-1:0]       r_beat_cnt;

  // Per-channel state exported from the generate block
  logic [ADDR_WIDTH-1:0]   w_wptr [CH_NUM];
  logic [CH_NUM-1:0]       w_half;
  logic [BEAT_W-1:0]       w_ch_data [CH_NUM];

  // Arbiter and datapath helpers
  logic                    w_found;
  logic [SEL_W-1:0]        w_winner;
  logic                    w_half_sel;
  logic [BCNT_W-1:0]       w_beat_inc;
  logic                    w_take_beat;
  logic                    w_burst_end;

  // Per-channel write pointer, ping-pong half, frame burst count and sticky
  // frame-end flag. Frame rewinds are applied only while the FSM idles, so a
  // burst in flight always finishes at the address it started with.
  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(gi * CH_STRIDE);

      logic [ADDR_WIDTH-1:0] r_wptr;
      logic                  r_half;
      logic [FCNT_W-1:0]     r_fcnt;
      logic                  r_pend;
      logic                  w_apply;
      logic                  w_adv;

      assign w_apply       = (r_state == S_IDLE) && r_pend;
      assign w_adv         = (r_state == S_DONE) && (r_grant == SEL_W'(gi));
      assign w_wptr[gi]    = r_wptr;
      assign w_half[gi]    = r_half;
      assign w_ch_data[gi] = ch_rd_data[gi*BEAT_W +: BEAT_W];

      // Advance after each served burst; rewind on a pending frame end.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wptr <= BASE;
          r_half <= 1'b0;
          r_fcnt <= '0;
          r_pend <= 1'b0;
        end else begin
          r_pend <= ch_frame_end[gi] | (r_pend & ~w_apply);
          if (w_apply) begin
            r_wptr <= BASE;
            r_half <= 1'b0;
            r_fcnt <= '0;
          end else if (w_adv) begin
            r_half <= ~r_half;
            if (r_fcnt == FCNT_W'(FRAME_BURSTS - 1)) begin
              r_wptr <= BASE;
              r_fcnt <= '0;
            end else begin
              r_wptr <= r_wptr + ADDR_WIDTH'(BURST_LEN);
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // Round-robin search starting just after the last winner.
  always_comb begin : p_arb
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = r_last_grant;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = (int'(r_last_grant) + i) % CH_NUM;
      if (!w_found && ch_data_ready[SEL_W'(idx)]) begin
        w_found  = 1'b1;
        w_winner = SEL_W'(idx);
      end
    end
  end

  assign w_half_sel  = w_half[r_grant];
  assign w_beat_inc  = r_beat_cnt + 1'b1;
  assign w_take_beat = ddr_wr_data_req && (r_beat_cnt < BCNT_W'(BURST_LEN));
  // Burst is complete once all beats were requested, including a done that
  // lands on the same cycle as the final data request.
  assign w_burst_end = ddr_wr_done &&
                       ((r_beat_cnt == BCNT_W'(BURST_LEN)) ||
                        (ddr_wr_data_req && (r_beat_cnt == BCNT_W'(BURST_LEN - 1))));

  // Burst sequencer: IDLE -> GRANT -> REQ -> DATA -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= SEL_W'(CH_NUM - 1);
      r_rd_valid   <= '0;
      r_rd_addr    <= '0;
      r_wr_req     <= 1'b0;
      r_wr_addr    <= '0;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|ch_data_ready) begin
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Ready may have dropped since IDLE looked; fall back if so.
          if (w_found) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_rd_valid   <= CH_NUM'(1) << w_winner;
            r_wr_req     <= 1'b1;
            r_wr_addr    <= w_wptr[w_winner];
            r_state      <= S_REQ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (ddr_wr_ack) begin
            r_wr_req  <= 1'b0;
            r_rd_addr <= {w_half_sel, {(RD_ADDR_LEN-1){1'b0}}};
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          // The address moves on with each request so the RAM's registered
          // output presents beat k in the cycle the master consumes it.
          if (w_take_beat) begin
            r_beat_cnt <= w_beat_inc;
            r_rd_addr  <= {w_half_sel, w_beat_inc[RD_ADDR_LEN-2:0]};
          end
          if (w_burst_end) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_rd_valid <= '0;
          r_rd_addr  <= '0;
          r_beat_cnt <= '0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ch_rd_valid = r_rd_valid;
  assign ch_rd_addr  = r_rd_addr;
  assign ddr_wr_req  = r_wr_req;
  assign ddr_wr_addr = r_wr_addr;
  assign ddr_wr_len  = 8'(BURST_LEN);
  assign ddr_wr_data = w_ch_data[r_grant];
  assign grant_id    = 4'(r_grant);

endmodule

// File: tb/tb_video_sampling_arbiter.sv
// Testbench for video_sampling_arbiter: emulates the channel buffers and the
// DDR write master, and checks every burst against a frame-level model.
module tb_video_sampling_arbiter;

  localparam int CH     = 4;
  localparam int RAL    = 5;
  localparam int DQ     = 32;
  localparam int BW     = DQ * 8;
  localparam int BL     = 16;
  localparam int AW     = 28;
  localparam int STRIDE = 4096;
  localparam int FB     = 225;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH-1:0]        ch_data_ready;
  logic [CH-1:0]        ch_frame_end;
  logic [CH*BW-1:0]     ch_rd_data;
  logic [CH-1:0]        ch_rd_valid;
  logic [RAL-1:0]       ch_rd_addr;
  logic                 ddr_wr_req;
  logic                 ddr_wr_ack;
  logic [AW-1:0]        ddr_wr_addr;
  logic [7:0]           ddr_wr_len;
  logic                 ddr_wr_data_req;
  logic [BW-1:0]        ddr_wr_data;
  logic                 ddr_wr_done;
  logic [3:0]           grant_id;

  always #5 clk = ~clk;

  video_sampling_arbiter #(
    .CH_NUM(CH), .RD_ADDR_LEN(RAL), .DQ_WIDTH(DQ), .BURST_LEN(BL),
    .ADDR_WIDTH(AW), .CH_STRIDE(STRIDE), .FRAME_BURSTS(FB)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_data_ready(ch_data_ready), .ch_frame_end(ch_frame_end),
    .ch_rd_data(ch_rd_data), .ch_rd_valid(ch_rd_valid), .ch_rd_addr(ch_rd_addr),
    .ddr_wr_req(ddr_wr_req), .ddr_wr_ack(ddr_wr_ack), .ddr_wr_addr(ddr_wr_addr),
    .ddr_wr_len(ddr_wr_len), .ddr_wr_data_req(ddr_wr_data_req),
    .ddr_wr_data(ddr_wr_data), .ddr_wr_done(ddr_wr_done), .grant_id(grant_id)
  );

  // Channel read buffers: 1-cycle registered read while serviced.
  logic [BW-1:0] mem [CH][2*BL];
  logic [BW-1:0] rd_reg [CH];

  always @(posedge clk) begin
    for (int n = 0; n < CH; n++)
      if (ch_rd_valid[n]) rd_reg[n] <= mem[n][ch_rd_addr];
  end

  always_comb begin
    ch_rd_data = '0;
    for (int n = 0; n < CH; n++) ch_rd_data[n*BW +: BW] = rd_reg[n];
  end

  int vec = 0;
  int err = 0;

  // Reference model: bursts served since the last frame start, per channel.
  int n_burst [CH];
  bit pend    [CH];
  int last_g;

  function automatic int model_addr(input int c);
    return c * STRIDE + BL * (n_burst[c] % FB);
  endfunction

  function automatic int model_half(input int c);
    return n_burst[c] % 2;
  endfunction

  function automatic int model_next(input logic [CH-1:0] mask);
    for (int i = 1; i <= CH; i++)
      if (mask[(last_g + i) % CH]) return (last_g + i) % CH;
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      n_burst[c] = 0;
      pend[c]    = 1'b0;
    end
    last_g = CH - 1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ch_data_ready = '0; ch_frame_end = '0;
    ddr_wr_ack = 1'b0; ddr_wr_data_req = 1'b0; ddr_wr_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One burst as seen by the DDR master. abort_beat >= 0 asserts rst instead
  // of that beat's data request; fe_beat >= 0 pulses fe_ch's frame end then.
  task automatic run_burst(input logic [CH-1:0] mask, input int ack_dly,
                           input int max_gap, input bit done_last,
                           input int fe_beat, input int fe_ch,
                           input int abort_beat);
    int c, lat, h, gap, exp_addr;
    bit got;
    logic [CH-1:0]  exp_vld;
    logic [RAL-1:0] exp_ra;
    c = model_next(mask);
    exp_vld = CH'(1) << c;
    exp_addr = model_addr(c);
    h = model_half(c);
    ch_data_ready = mask;
    got = 1'b0; lat = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      lat++;
      if (ddr_wr_req === 1'b1) begin got = 1'b1; break; end
    end
    vec++;
    if (!got || lat != 2) begin
      err++;
      $display("FAIL req_latency: got %0d cycles (seen=%0d) expected 2", lat, got);
      ch_data_ready = '0;
      return;
    end
    vec++;
    if (grant_id !== 4'(c)) begin
      err++; $display("FAIL grant_id: got %0d expected %0d", grant_id, c);
    end
    vec++;
    if (ch_rd_valid !== exp_vld) begin
      err++; $display("FAIL rd_valid: got %b expected %b", ch_rd_valid, exp_vld);
    end
    vec++;
    if (ddr_wr_addr !== AW'(exp_addr)) begin
      err++; $display("FAIL wr_addr ch%0d: got %0d expected %0d", c, ddr_wr_addr, exp_addr);
    end
    repeat (ack_dly) begin
      @(negedge clk);
      vec++;
      if (ddr_wr_req !== 1'b1 || ddr_wr_addr !== AW'(exp_addr)) begin
        err++; $display("FAIL req_hold: got req=%b addr=%0d expected req=1 addr=%0d",
                        ddr_wr_req, ddr_wr_addr, exp_addr);
      end
    end
    ddr_wr_ack = 1'b1;
    @(negedge clk);
    ddr_wr_ack = 1'b0;
    vec++;
    if (ddr_wr_req !== 1'b0) begin
      err++; $display("FAIL req_clear: got %b expected 0", ddr_wr_req);
    end
    for (int k = 0; k < BL; k++) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin ddr_wr_data_req = 1'b0; @(negedge clk); end
      if (k == abort_beat) begin
        ddr_wr_data_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (ch_rd_valid !== '0 || ch_rd_addr !== '0 || ddr_wr_req !== 1'b0 ||
            grant_id !== 4'd0 || ddr_wr_addr !== '0) begin
          err++; $display("FAIL abort_reset: got vld=%b ra=%0d req=%b gid=%0d wa=%0d expected all 0",
                          ch_rd_valid, ch_rd_addr, ddr_wr_req, grant_id, ddr_wr_addr);
        end
        rst = 1'b0;
        ch_data_ready = '0;
        model_reset();
        return;
      end
      exp_ra = RAL'(h * BL + k);
      vec++;
      if (ch_rd_addr !== exp_ra) begin
        err++; $display("FAIL rd_addr ch%0d beat%0d: got %0d expected %0d", c, k, ch_rd_addr, exp_ra);
      end
      ddr_wr_data_req = 1'b1;
      if (k == BL - 1 && done_last) ddr_wr_done = 1'b1;
      if (k == fe_beat) begin ch_frame_end = CH'(1) << fe_ch; pend[fe_ch] = 1'b1; end
      @(negedge clk);
      ch_frame_end = '0;
      ddr_wr_done = 1'b0;
      vec++;
      if (ddr_wr_data !== mem[c][exp_ra]) begin
        err++; $display("FAIL wr_data ch%0d beat%0d: got %h expected %h", c, k, ddr_wr_data, mem[c][exp_ra]);
      end
    end
    ddr_wr_data_req = 1'b0;
    if (!done_last) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ddr_wr_done = 1'b1;
      @(negedge clk);
      ddr_wr_done = 1'b0;
    end
    vec++;
    if (ch_rd_valid !== exp_vld) begin
      err++; $display("FAIL done_valid: got %b expected %b", ch_rd_valid, exp_vld);
    end
    ch_data_ready = '0;
    @(negedge clk);
    vec++;
    if (ch_rd_valid !== '0 || ch_rd_addr !== '0 || ddr_wr_req !== 1'b0) begin
      err++; $display("FAIL idle_outputs: got vld=%b ra=%0d req=%b expected 0/0/0",
                      ch_rd_valid, ch_rd_addr, ddr_wr_req);
    end
    n_burst[c]++;
    last_g = c;
    for (int n = 0; n < CH; n++)
      if (pend[n]) begin n_burst[n] = 0; pend[n] = 1'b0; end
  endtask

  task automatic test_reset();
    apply_reset();
    vec++;
    if (ch_rd_valid !== '0 || ch_rd_addr !== '0 || ddr_wr_req !== 1'b0 ||
        ddr_wr_addr !== '0 || grant_id !== 4'd0) begin
      err++; $display("FAIL reset_outputs: got vld=%b ra=%0d req=%b wa=%0d gid=%0d expected all 0",
                      ch_rd_valid, ch_rd_addr, ddr_wr_req, ddr_wr_addr, grant_id);
    end
    vec++;
    if (ddr_wr_len !== 8'd16) begin
      err++; $display("FAIL wr_len: got %0d expected 16", ddr_wr_len);
    end
    repeat (4) begin
      @(negedge clk);
      vec++;
      if (ddr_wr_req !== 1'b0 || ch_rd_valid !== '0) begin
        err++; $display("FAIL idle_hold: got req=%b vld=%b expected 0", ddr_wr_req, ch_rd_valid);
      end
    end
  endtask

  task automatic test_single_channel();
    run_burst(4'b0100, 2, 1, 1'b0, -1, 0, -1);
    run_burst(4'b0100, 2, 0, 1'b1, -1, 0, -1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 8; i++)
      run_burst(4'b1111, $urandom_range(0, 2), 1, 1'($urandom_range(0, 1)), -1, 0, -1);
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    for (int i = 0; i < FB + 1; i++)
      run_burst(4'b0010, $urandom_range(0, 1), 0, 1'($urandom_range(0, 1)), -1, 0, -1);
  endtask

  task automatic test_frame_end();
    apply_reset();
    for (int i = 0; i < 3; i++) run_burst(4'b0001, 0, 0, 1'b0, -1, 0, -1);
    run_burst(4'b0001, 1, 1, 1'b0, 5, 0, -1);
    run_burst(4'b0001, 0, 0, 1'b0, -1, 0, -1);
    run_burst(4'b0001, 0, 0, 1'b1, -1, 0, -1);
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 4; i++) run_burst(4'b1111, 0, 0, 1'b0, -1, 0, -1);
    run_burst(4'b1111, 1, 0, 1'b0, -1, 0, 7);
    for (int i = 0; i < 4; i++) run_burst(4'b1111, 0, 1, 1'b0, -1, 0, -1);
  endtask

  task automatic test_random();
    int fe_beat, fe_ch;
    for (int i = 0; i < 40; i++) begin
      fe_beat = -1; fe_ch = 0;
      if ($urandom_range(0, 3) == 0) begin
        fe_beat = $urandom_range(0, BL - 1);
        fe_ch   = $urandom_range(0, CH - 1);
      end
      run_burst(CH'($urandom_range(1, 15)), $urandom_range(0, 3), 2,
                1'($urandom_range(0, 1)), fe_beat, fe_ch, -1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int n = 0; n < CH; n++) begin
      rd_reg[n] = '0;
      for (int a = 0; a < 2*BL; a++) mem[n][a] = {8{$urandom}};
    end
    rst = 1'b1;
    ch_data_ready = '0; ch_frame_end = '0;
    ddr_wr_ack = 1'b0; ddr_wr_data_req = 1'b0; ddr_wr_done = 1'b0;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_frame_wrap();
    test_frame_end();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
